dest_reader: RTL and testbench

//  Consumer end of the transaction layer: drains destination FIFOs D0/D1 through their pop/almost-empty/empty interface.

---
 rtl/dest_reader.sv | 198 +++++++++++++++++++
 tb/tb_dest_reader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dest_reader.sv
// -----------------------------------------------------------------------------
// dest_reader
//
// Consumer end of the transaction layer. Drains the two destination FIFOs
// (D0, D1) through their pop / almost-empty / empty interface, issuing at most
// one registered pop per cycle. Popped words come back one cycle after the pop
// and are captured into a single registered output stream tagged with the
// source destination. Per-destination received-word counters wrap freely.
//
// Optional feature (macro DEST_CHECK_EN):
//   defined   - each captured word's destination bit (DATA_W-2) is compared
//               with the FIFO it came from; a mismatch sets a sticky error that
//               rises in the same cycle the word is presented on valid_out_o.
//   undefined - no destination check, error_out_o is tied low.
//
// Ports:
//   clk_i               system clock, rising edge
//   rst_ni              asynchronous active-low reset
//   init_i              synchronous re-initialisation (wins over enable_i)
//   enable_i            allow new pops; an in-flight read still completes
//   data_in_d0_i/d1_i   FIFO read data, valid the cycle after the pop
//   empty_d0_i/d1_i     FIFO empty flags
//   almost_empty_d0_i/d1_i  FIFO at/below almost-empty threshold
//   pop_d0_o/pop_d1_o   registered pop strobes
//   data_out_o          captured word (holds when valid_out_o is low)
//   valid_out_o         data_out_o valid this cycle
//   dest_out_o          0 = word from D0, 1 = word from D1
//   cnt_d0_o/cnt_d1_o   words received per destination (wrapping)
//   error_out_o         sticky destination-mismatch error
//   idle_out_o          FSM idle, nothing in flight, both FIFOs empty
// -----------------------------------------------------------------------------
module dest_reader #(
   parameter int unsigned DATA_W = 6,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              init_i,
   input  logic              enable_i,
   input  logic [DATA_W-1:0] data_in_d0_i,
   input  logic [DATA_W-1:0] data_in_d1_i,
   input  logic              empty_d0_i,
   input  logic              empty_d1_i,
   input  logic              almost_empty_d0_i,
   input  logic              almost_empty_d1_i,
   output logic              pop_d0_o,
   output logic              pop_d1_o,
   output logic [DATA_W-1:0] data_out_o,
   output logic              valid_out_o,
   output logic              dest_out_o,
   output logic [CNT_W-1:0]  cnt_d0_o,
   output logic [CNT_W-1:0]  cnt_d1_o,
   output logic              error_out_o,
   output logic              idle_out_o
);

   typedef enum logic {StIdle, StActive} state_e;

   state_e            state_q, state_d;
   logic              pop_d0_q, pop_d1_q;
   logic              rr_q;          // 0: D0 next on a round-robin tie
   logic              pend_q;        // a read returns data this cycle
   logic              pend_dest_q;   // source of that read
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic              dest_q;
   logic [CNT_W-1:0]  cnt_d0_q, cnt_d1_q;
   logic              idle_q, idle_d;

   logic              elig_d0, elig_d1;
   logic              grant_d0, grant_d1;
   logic              grant_any, inflight;
   logic [DATA_W-1:0] cap_data;

   // Eligibility and arbitration. The FIFO flags lag a pop by one cycle, so a
   // FIFO popped last cycle that already reports almost-empty may hold no
   // further word and is skipped this edge.
   always_comb begin
      elig_d0 = enable_i & ~empty_d0_i & ~(pop_d0_q & almost_empty_d0_i);
      elig_d1 = enable_i & ~empty_d1_i & ~(pop_d1_q & almost_empty_d1_i);
      grant_d0 = 1'b0;
      grant_d1 = 1'b0;
      if (elig_d0 && elig_d1) begin
         if (almost_empty_d0_i != almost_empty_d1_i) begin
            // Favour the FIFO with more headroom.
            grant_d0 = ~almost_empty_d0_i;
            grant_d1 = ~almost_empty_d1_i;
         end else begin
            grant_d0 = ~rr_q;
            grant_d1 = rr_q;
         end
      end else begin
         grant_d0 = elig_d0;
         grant_d1 = elig_d1;
      end
      grant_any = grant_d0 | grant_d1;
   end

   // Next state and idle flag.
   always_comb begin
      inflight = pop_d0_q | pop_d1_q | pend_q;
      state_d  = state_q;
      if (state_q == StIdle) begin
         if (grant_any) begin
            state_d = StActive;
         end
      end else begin
         // Stay active until the last outstanding read has been captured.
         if (!grant_any && !inflight) begin
            state_d = StIdle;
         end
      end
      idle_d = (state_d == StIdle) & empty_d0_i & empty_d1_i;
   end

   assign cap_data = pend_dest_q ? data_in_d1_i : data_in_d0_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         pop_d0_q    <= 1'b0;
         pop_d1_q    <= 1'b0;
         rr_q        <= 1'b0;
         pend_q      <= 1'b0;
         pend_dest_q <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         dest_q      <= 1'b0;
         cnt_d0_q    <= '0;
         cnt_d1_q    <= '0;
         idle_q      <= 1'b1;
      end else if (init_i) begin
         // Any read in flight is dropped, nothing is emitted.
         state_q     <= StIdle;
         pop_d0_q    <= 1'b0;
         pop_d1_q    <= 1'b0;
         rr_q        <= 1'b0;
         pend_q      <= 1'b0;
         pend_dest_q <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         dest_q      <= 1'b0;
         cnt_d0_q    <= '0;
         cnt_d1_q    <= '0;
         idle_q      <= 1'b1;
      end else begin
         state_q  <= state_d;
         pop_d0_q <= grant_d0;
         pop_d1_q <= grant_d1;
         if (grant_any) begin
            rr_q <= ~rr_q;
         end
         // Pop in cycle N -> data on data_in in N+1 -> captured at end of N+1.
         pend_q      <= pop_d0_q | pop_d1_q;
         pend_dest_q <= pop_d1_q;
         valid_q     <= pend_q;
         if (pend_q) begin
            data_q <= cap_data;
            dest_q <= pend_dest_q;
            if (pend_dest_q) begin
               cnt_d1_q <= cnt_d1_q + CNT_W'(1);
            end else begin
               cnt_d0_q <= cnt_d0_q + CNT_W'(1);
            end
         end
         idle_q <= idle_d;
      end
   end

`ifdef DEST_CHECK_EN
   logic error_q;

   // Set on the capture edge so the flag rises with valid_out_o.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         error_q <= 1'b0;
      end else if (init_i) begin
         error_q <= 1'b0;
      end else if (pend_q && (cap_data[DATA_W-2] != pend_dest_q)) begin
         error_q <= 1'b1;
      end
   end

   assign error_out_o = error_q;
`else
   assign error_out_o = 1'b0;
`endif

   assign pop_d0_o    = pop_d0_q;
   assign pop_d1_o    = pop_d1_q;
   assign data_out_o  = data_q;
   assign valid_out_o = valid_q;
   assign dest_out_o  = dest_q;
   assign cnt_d0_o    = cnt_d0_q;
   assign cnt_d1_o    = cnt_d1_q;
   assign idle_out_o  = idle_q;

endmodule

// File: tb/tb_dest_reader.sv
// -----------------------------------------------------------------------------
// tb_dest_reader
//
// Directed bench for dest_reader. Two behavioural FIFOs (queues with
// size-derived empty / almost-empty flags and one-cycle read data) feed the
// DUT. Expected {dest, data} words are queued as stimulus is loaded; a
// monitor on the falling edge pops and compares every valid output word.
// -----------------------------------------------------------------------------
module tb_dest_reader;

   localparam int unsigned DATA_W = 6;
   localparam int unsigned CNT_W  = 8;
`ifdef DEST_CHECK_EN
   localparam int unsigned ExpErr = 1;
`else
   localparam int unsigned ExpErr = 0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              init;
   logic              enable;
   logic [DATA_W-1:0] d0, d1;
   logic              empty_d0, empty_d1, ae_d0, ae_d1;
   logic              pop_d0, pop_d1;
   logic [DATA_W-1:0] data_out;
   logic              valid_out, dest_out;
   logic [CNT_W-1:0]  cnt_d0, cnt_d1;
   logic              error_out, idle_out;

   always #5 clk = ~clk;

   dest_reader #(
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .init_i           (init),
      .enable_i         (enable),
      .data_in_d0_i     (d0),
      .data_in_d1_i     (d1),
      .empty_d0_i       (empty_d0),
      .empty_d1_i       (empty_d1),
      .almost_empty_d0_i(ae_d0),
      .almost_empty_d1_i(ae_d1),
      .pop_d0_o         (pop_d0),
      .pop_d1_o         (pop_d1),
      .data_out_o       (data_out),
      .valid_out_o      (valid_out),
      .dest_out_o       (dest_out),
      .cnt_d0_o         (cnt_d0),
      .cnt_d1_o         (cnt_d1),
      .error_out_o      (error_out),
      .idle_out_o       (idle_out)
   );

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, int unsigned act, int unsigned exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endfunction

   // Behavioural FIFOs and scoreboard.
   logic [DATA_W-1:0] q0[$];
   logic [DATA_W-1:0] q1[$];
   logic [DATA_W:0]   exp_q[$];
   logic [DATA_W:0]   mon_exp;
   int                thr0, thr1, underflow;
   int                first_pop_cyc, first_valid_cyc;
   logic              sb_on = 1'b0;

   task automatic refresh_flags();
      empty_d0 = (q0.size() == 0);
      empty_d1 = (q1.size() == 0);
      ae_d0    = (q0.size() <= thr0);
      ae_d1    = (q1.size() <= thr1);
   endtask

   // One clock: the pop seen this cycle is applied just after the edge, so
   // read data and flags change one cycle after the pop strobe.
   task automatic tick();
      logic p0, p1;
      p0 = pop_d0;
      p1 = pop_d1;
      if ((p0 || p1) && first_pop_cyc < 0) first_pop_cyc = cyc;
      @(posedge clk);
      #1;
      if (p0) begin
         if (q0.size() == 0) underflow++;
         else d0 = q0.pop_front();
      end
      if (p1) begin
         if (q1.size() == 0) underflow++;
         else d1 = q1.pop_front();
      end
      refresh_flags();
   endtask

   task automatic load(input logic dest, input logic [DATA_W-1:0] w, input logic expect_out);
      if (dest) q1.push_back(w);
      else q0.push_back(w);
      if (expect_out) exp_q.push_back({dest, w});
      refresh_flags();
   endtask

   task automatic check_cleared(string tag);
      check({tag, "_pop_d0"}, pop_d0, 0);
      check({tag, "_pop_d1"}, pop_d1, 0);
      check({tag, "_valid"}, valid_out, 0);
      check({tag, "_data"}, data_out, 0);
      check({tag, "_dest"}, dest_out, 0);
      check({tag, "_cnt_d0"}, cnt_d0, 0);
      check({tag, "_cnt_d1"}, cnt_d1, 0);
      check({tag, "_error"}, error_out, 0);
      check({tag, "_idle"}, idle_out, 1);
   endtask

   task automatic restart();
      enable = 1'b0;
      init   = 1'b1;
      tick();
      tick();
      check_cleared("init");
      q0.delete();
      q1.delete();
      exp_q.delete();
      thr0 = 1;
      thr1 = 1;
      underflow = 0;
      first_pop_cyc = -1;
      first_valid_cyc = -1;
      refresh_flags();
      tick();
      init  = 1'b0;
      sb_on = 1'b1;
   endtask

   task automatic drain(string tag, int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
      repeat (3) tick();
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (sb_on && valid_out) begin
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         check("sb_word_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check("sb_dest_data", {dest_out, data_out}, mon_exp);
         end
      end
   end

   initial begin
      logic seen;
      int   n;
      rst_n = 1'b0;
      init = 1'b0;
      enable = 1'b0;
      d0 = '0;
      d1 = '0;
      thr0 = 1;
      thr1 = 1;
      underflow = 0;
      first_pop_cyc = -1;
      first_valid_cyc = -1;
      refresh_flags();
      repeat (2) @(posedge clk);
      #1;
      check_cleared("reset");

      // 1: asynchronous reset while both FIFOs stream.
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         load(1'b0, 6'(i + 1), 1'b0);
         load(1'b1, 6'(i + 17), 1'b0);
      end
      enable = 1'b1;
      repeat (4) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_cleared("t1_async_reset");
      tick();
      tick();
      enable = 1'b0;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         tick();
         if (pop_d0 || pop_d1) seen = 1'b1;
      end
      check("t1_no_pop_while_disabled", seen, 0);
      restart();

      // 2: three D0 words, D1 empty; first word appears two cycles after pop.
      load(1'b0, 6'h05, 1'b1);
      load(1'b0, 6'h0A, 1'b1);
      load(1'b0, 6'h11, 1'b1);
      enable = 1'b1;
      drain("t2", 50);
      check("t2_cnt_d0", cnt_d0, 3);
      check("t2_cnt_d1", cnt_d1, 0);
      check("t2_latency", first_valid_cyc - first_pop_cyc, 2);
      check("t2_underflow", underflow, 0);
      check("t2_idle", idle_out, 1);
      restart();

      // 3: four words each; round-robin from D0 until D0 turns almost-empty,
      // then headroom priority and the popped-last rule order the tail.
      for (int i = 0; i < 4; i++) begin
         load(1'b0, 6'(i + 1), 1'b0);
         load(1'b1, 6'(i + 17), 1'b0);
      end
      exp_q.push_back({1'b0, 6'h01});
      exp_q.push_back({1'b1, 6'h11});
      exp_q.push_back({1'b0, 6'h02});
      exp_q.push_back({1'b1, 6'h12});
      exp_q.push_back({1'b0, 6'h03});
      exp_q.push_back({1'b1, 6'h13});
      exp_q.push_back({1'b1, 6'h14});
      exp_q.push_back({1'b0, 6'h04});
      enable = 1'b1;
      drain("t3", 60);
      check("t3_cnt_d0", cnt_d0, 4);
      check("t3_cnt_d1", cnt_d1, 4);
      check("t3_underflow", underflow, 0);
      restart();

      // 4: D0 one word (almost-empty), D1 five words: D1 drains first.
      load(1'b0, 6'h0A, 1'b0);
      for (int i = 0; i < 5; i++) load(1'b1, 6'(i + 21), 1'b1);
      exp_q.push_back({1'b0, 6'h0A});
      enable = 1'b1;
      drain("t4", 60);
      check("t4_cnt_d0", cnt_d0, 1);
      check("t4_cnt_d1", cnt_d1, 5);
      check("t4_underflow", underflow, 0);
      restart();

      // enable dropped right after the first pop: that read still lands.
      for (int i = 0; i < 4; i++) load(1'b0, 6'(i + 1), i == 0);
      enable = 1'b1;
      tick();
      enable = 1'b0;
      drain("en_drop", 30);
      check("en_drop_cnt_d0", cnt_d0, 1);
      check("en_drop_fifo_left", q0.size(), 3);
      restart();

      // init mid-stream: pending read discarded, nothing emitted.
      for (int i = 0; i < 3; i++) load(1'b0, 6'(i + 1), 1'b0);
      enable = 1'b1;
      tick();
      tick();
      init = 1'b1;
      repeat (3) tick();
      check("init_mid_valid", valid_out, 0);
      check("init_mid_cnt_d0", cnt_d0, 0);
      check("init_mid_idle", idle_out, 1);
      restart();

      // 5: counter wrap on D1.
      for (int i = 0; i < 255; i++) load(1'b1, 6'(16 + (i % 16)), 1'b1);
      enable = 1'b1;
      drain("t5_fill", 1200);
      check("t5_cnt_d1_255", cnt_d1, 255);
      load(1'b1, 6'h1F, 1'b1);
      drain("t5_wrap", 30);
      check("t5_cnt_d1_wrap", cnt_d1, 0);
      check("t5_cnt_d0", cnt_d0, 0);
      check("t5_error", error_out, 0);
      check("t5_underflow", underflow, 0);
      restart();

      // 6: D0 delivers a word tagged for D1.
      load(1'b0, 6'h30, 1'b1);
      enable = 1'b1;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 20) begin
         tick();
         n++;
         if (valid_out) begin
            seen = 1'b1;
            check("t6_dest", dest_out, 0);
            check("t6_error_with_valid", error_out, ExpErr);
         end
      end
      check("t6_valid_seen", seen, 1);
      repeat (4) tick();
      check("t6_error_sticky", error_out, ExpErr);
      check("t6_cnt_d0", cnt_d0, 1);
      restart();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
